// File: rtl/mux8_sched_pkg.sv
// mux8_sched_pkg
//   Shared definitions for the 8-source round-robin mux-tree scheduler.
//   N_SRC    : number of requesting sources (mux inputs S0..S7)
//   SEL_W    : width of the mux select bus / source index
//   CNT_W    : width of the dwell counter (DWELL_CYC up to 15)
//   sched_state_t : scheduler FSM states
//   onehot8  : source index -> one-hot grant vector
package mux8_sched_pkg;

    localparam int unsigned N_SRC = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE,
        DWELL
    } sched_state_t;

    function automatic logic [N_SRC-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [N_SRC-1:0] vec;
        vec = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// rr_pick8
//   Combinational round-robin picker. Searches req starting one position
//   after the last-granted pointer and wrapping modulo 8; the pointer's own
//   bit is examined last, so a lone requester can win again.
//   Ports:
//     req [7:0] in  : per-source request vector
//     ptr [2:0] in  : last-granted source index
//     idx [2:0] out : winning source index (0 when nothing requests)
//     any       out : 1 when at least one req bit is set
module rr_pick8
    import mux8_sched_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    always_comb begin
        logic [SEL_W-1:0] cand;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        // Offsets 1..8; offset 8 truncates to ptr itself.
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            cand = ptr + SEL_W'(k);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched
//   Round-robin scheduler sharing one 8:1 mux tree among 8 sources. Drives
//   the tree select lines, holds each grant for DWELL_CYC cycles so the tree
//   output settles, then samples F into a registered data word tagged with
//   the source index. Under continuous requests a new grant is issued on the
//   same edge that completes the previous one (no idle gap).
//
//   Parameter:
//     DWELL_CYC  : cycles each grant is held before F is sampled (1..15)
//
//   Optional build macro:
//     MUX8_SCHED_LOCK_EN : when defined, a source with both lock[i] and
//                          req[i] set at its dwell end is granted again,
//                          ignoring other requesters. When undefined the
//                          lock input is unused and arbitration is pure
//                          round-robin.
//
//   Ports:
//     clk        in  : system clock, rising edge
//     reset      in  : asynchronous active-high reset
//     req  [7:0] in  : per-source request, bit i requests mux input Si
//     lock [7:0] in  : per-source grant-hold request (lock build only)
//     f_in       in  : mux tree output F
//     sel  [2:0] out : mux select; sel[2]=W0, sel[1]=W1, sel[0]=W2
//     grant[7:0] out : one-hot current grant, zero when idle
//     busy       out : high while a grant is dwelling
//     data_out   out : F sampled at the end of a dwell
//     data_idx[2:0] out : source index of data_out
//     data_valid out : one-cycle pulse qualifying data_out/data_idx
module mux8_rr_sched
    import mux8_sched_pkg::*;
#(
    parameter int unsigned DWELL_CYC = 2
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] req,
    input  logic [N_SRC-1:0] lock,
    input  logic             f_in,
    output logic [SEL_W-1:0] sel,
    output logic [N_SRC-1:0] grant,
    output logic             busy,
    output logic             data_out,
    output logic [SEL_W-1:0] data_idx,
    output logic             data_valid
);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL_CYC - 1);

    sched_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] ptr;

    // At a dwell end the pointer advances to the source just served, so the
    // picker must already search from sel on that edge rather than from the
    // stale ptr register.
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic [SEL_W-1:0] arb_idx;
    logic             arb_any;

    assign pick_ptr = (state == DWELL) ? sel : ptr;

    rr_pick8 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef MUX8_SCHED_LOCK_EN
    logic hold;

    // Lock only matters when re-arbitrating at a dwell end; in IDLE there is
    // no current owner to hold.
    assign hold    = (state == DWELL) && lock[sel] && req[sel];
    assign arb_idx = hold ? sel : pick_idx;
    assign arb_any = hold | pick_any;
`else
    logic unused_lock;

    assign unused_lock = ^lock;
    assign arb_idx     = pick_idx;
    assign arb_any     = pick_any;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= '1;
            sel        <= '0;
            grant      <= '0;
            busy       <= 1'b0;
            data_out   <= 1'b0;
            data_idx   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // sel keeps its last value while idle.
                    if (arb_any) begin
                        grant <= onehot8(arb_idx);
                        sel   <= arb_idx;
                        busy  <= 1'b1;
                        cnt   <= CNT_RELOAD;
                        state <= DWELL;
                    end
                end
                DWELL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        data_out   <= f_in;
                        data_idx   <= sel;
                        data_valid <= 1'b1;
                        ptr        <= sel;
                        if (arb_any) begin
                            grant <= onehot8(arb_idx);
                            sel   <= arb_idx;
                            cnt   <= CNT_RELOAD;
                        end else begin
                            grant <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux8_rr_sched.sv
// tb_mux8_rr_sched
//   Directed testbench for mux8_rr_sched. Two instances share clock, reset
//   and f_in: u_dut2 (DWELL_CYC=2) for most scenarios and u_dut4
//   (DWELL_CYC=4) for the long-dwell request-drop case. Inputs change and
//   outputs are sampled 1 ns after each rising edge.
module tb_mux8_rr_sched;

    logic       clk;
    logic       reset;
    logic       f_in;
    logic [7:0] req2, lock2, req4, lock4;

    logic [2:0] sel2, sel4;
    logic [7:0] grant2, grant4;
    logic       busy2, busy4;
    logic       dout2, dout4;
    logic [2:0] didx2, didx4;
    logic       dv2, dv4;

    int n_checks;
    int n_errors;

    mux8_rr_sched #(.DWELL_CYC(2)) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .req        (req2),
        .lock       (lock2),
        .f_in       (f_in),
        .sel        (sel2),
        .grant      (grant2),
        .busy       (busy2),
        .data_out   (dout2),
        .data_idx   (didx2),
        .data_valid (dv2)
    );

    mux8_rr_sched #(.DWELL_CYC(4)) u_dut4 (
        .clk        (clk),
        .reset      (reset),
        .req        (req4),
        .lock       (lock4),
        .f_in       (f_in),
        .sel        (sel4),
        .grant      (grant4),
        .busy       (busy4),
        .data_out   (dout4),
        .data_idx   (didx4),
        .data_valid (dv4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_g;
        logic [2:0] exp_i;

        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        f_in  = 1'b0;
        req2  = '0;
        lock2 = '0;
        req4  = '0;
        lock4 = '0;
        step();
        step();

        // Reset values
        check("rst_grant", grant2, 8'h00);
        check("rst_sel",   {5'd0, sel2}, 8'h00);
        check("rst_busy",  {7'd0, busy2}, 8'h00);
        check("rst_dout",  {7'd0, dout2}, 8'h00);
        check("rst_didx",  {5'd0, didx2}, 8'h00);
        check("rst_dv",    {7'd0, dv2}, 8'h00);
        check("rst_grant4", grant4, 8'h00);
        reset = 1'b0;

        // Reset mid-dwell: immediate abort, no data_valid
        req2 = 8'h01;
        step();
        check("mid_grant", grant2, 8'h01);
        check("mid_busy",  {7'd0, busy2}, 8'h01);
        reset = 1'b1;
        #1;
        check("mid_rst_grant", grant2, 8'h00);
        check("mid_rst_busy",  {7'd0, busy2}, 8'h00);
        step();
        check("mid_rst_dv", {7'd0, dv2}, 8'h00);
        reset = 1'b0;
        step();
        check("mid_regrant", grant2, 8'h01);
        req2 = 8'h00;
        step();
        check("mid_dv_lo", {7'd0, dv2}, 8'h00);
        step();
        check("mid_dv_hi", {7'd0, dv2}, 8'h01);
        check("mid_idx",   {5'd0, didx2}, 8'h00);
        check("mid_idle",  grant2, 8'h00);

        // Single request from S5 with F=1
        req2 = 8'h20;
        f_in = 1'b1;
        step();
        check("s5_sel",   {5'd0, sel2}, 8'h05);
        check("s5_grant", grant2, 8'h20);
        check("s5_busy",  {7'd0, busy2}, 8'h01);
        req2 = 8'h00;
        step();
        check("s5_dv_lo", {7'd0, dv2}, 8'h00);
        check("s5_hold",  grant2, 8'h20);
        step();
        check("s5_dv",    {7'd0, dv2}, 8'h01);
        check("s5_dout",  {7'd0, dout2}, 8'h01);
        check("s5_idx",   {5'd0, didx2}, 8'h05);
        check("s5_grant0", grant2, 8'h00);
        check("s5_busy0", {7'd0, busy2}, 8'h00);
        check("s5_sel_keep", {5'd0, sel2}, 8'h05);
        step();
        check("s5_dv_pulse", {7'd0, dv2}, 8'h00);
        f_in = 1'b0;

        // All requesting: 0,1,...,7,0 with back-to-back grants
        pulse_reset();
        req2 = 8'hFF;
        step();
        check("all_first", grant2, 8'h01);
        for (int i = 0; i < 9; i++) begin
            step();
            check("all_dv_lo", {7'd0, dv2}, 8'h00);
            f_in = i[0];
            step();
            exp_i = 3'(i % 8);
            exp_g = 8'h01 << ((i + 1) % 8);
            check("all_dv",    {7'd0, dv2}, 8'h01);
            check("all_idx",   {5'd0, didx2}, {5'd0, exp_i});
            check("all_dout",  {7'd0, dout2}, {7'd0, i[0]});
            check("all_grant", grant2, exp_g);
            check("all_busy",  {7'd0, busy2}, 8'h01);
        end
        f_in = 1'b0;

        // Wrap and skip: grant 1 in flight, then 6,0,6,0
        req2 = 8'h41;
        step();
        step();
        check("ws_idx1",   {5'd0, didx2}, 8'h01);
        check("ws_grant6", grant2, 8'h40);
        for (int j = 0; j < 3; j++) begin
            step();
            step();
            check("ws_dv",    {7'd0, dv2}, 8'h01);
            check("ws_idx",   {5'd0, didx2}, (j % 2 == 0) ? 8'h06 : 8'h00);
            check("ws_grant", grant2, (j % 2 == 0) ? 8'h01 : 8'h40);
        end
        req2 = 8'h00;
        step();
        step();
        check("ws_last_idx", {5'd0, didx2}, 8'h00);
        check("ws_idle",     {7'd0, busy2}, 8'h00);

        // Request drop with DWELL_CYC=4: grant held, one data_valid
        req4 = 8'h08;
        step();
        check("rd_grant", grant4, 8'h08);
        req4 = 8'h00;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rd_hold",  grant4, 8'h08);
            check("rd_dv_lo", {7'd0, dv4}, 8'h00);
        end
        f_in = 1'b1;
        step();
        check("rd_dv",    {7'd0, dv4}, 8'h01);
        check("rd_idx",   {5'd0, didx4}, 8'h03);
        check("rd_dout",  {7'd0, dout4}, 8'h01);
        check("rd_grant0", grant4, 8'h00);
        check("rd_busy0", {7'd0, busy4}, 8'h00);
        step();
        check("rd_dv_once", {7'd0, dv4}, 8'h00);
        f_in = 1'b0;

        // Lock behaviour (pure round-robin when the macro is undefined)
        pulse_reset();
        req2  = 8'h03;
        lock2 = 8'h01;
        step();
        check("lk_first", grant2, 8'h01);
        for (int j = 0; j < 4; j++) begin
            if (j == 3) lock2 = 8'h00;
            step();
            step();
`ifdef MUX8_SCHED_LOCK_EN
            exp_i = 3'd0;
            exp_g = (j == 3) ? 8'h02 : 8'h01;
`else
            exp_i = (j % 2 == 0) ? 3'd0 : 3'd1;
            exp_g = (j % 2 == 0) ? 8'h02 : 8'h01;
`endif
            check("lk_dv",    {7'd0, dv2}, 8'h01);
            check("lk_idx",   {5'd0, didx2}, {5'd0, exp_i});
            check("lk_grant", grant2, exp_g);
        end
        req2 = 8'h00;
        step();
        step();
        check("lk_idle", grant2, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux8_rr_sched.md
Name: mux8_rr_sched

Overview:
Round-robin scheduler that shares the 8:1 mux tree (four 2:1 stages feeding a 4:1 stage) among 8 requesting sources. It drives the tree select lines and holds each grant for a fixed dwell so the mux output settles. It then samples the tree output F back into a registered data word tagged with the source index. It sits directly beside the mux tree: select lines out, F in.

Parameters:
DWELL_CYC, 2, cycles each grant is held before sampling F; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  8  per-source request; bit i requests mux input Si
lock  in  8  per-source grant-hold request; used only with MUX8_SCHED_LOCK_EN
f_in  in  1  mux tree output F
sel  out  3  mux select; sel[2]=W0, sel[1]=W1, sel[0]=W2; source index i = sel
grant  out  8  one-hot current grant; all zero when idle
busy  out  1  1 while in DWELL
data_out  out  1  F sampled at end of dwell
data_idx  out  3  source index of data_out
data_valid  out  1  one-cycle pulse, data_out/data_idx valid

Behaviour:
- Reset (async, active-high): state=IDLE, grant=0, sel=0, busy=0, data_out=0, data_idx=0, data_valid=0, last-grant pointer ptr=7 (source 0 wins first).
- Reset asserted mid-dwell: immediate abort to reset values, no data_valid for the aborted grant.
- Pick rule: the first set req bit searching ptr+1, ptr+2, ... mod 8.
- IDLE: if any req bit is set at a rising edge, at that edge: grant=onehot(pick), sel=pick, busy=1, cnt=DWELL_CYC-1, go to DWELL. Else all outputs hold; sel keeps its last value.
- DWELL, cnt>0: cnt decrements. grant and sel are stable. A req drop does not revoke the grant.
- DWELL, cnt==0 (edge k+DWELL_CYC, where edge k granted):
  - data_out=f_in, data_idx=sel, data_valid=1, ptr=sel.
  - If any req is set (new ptr), re-arbitrate at the same edge: new grant/sel, cnt reloaded, stay in DWELL. There is no idle gap.
  - Else: grant=0, busy=0, go to IDLE.
- data_valid is high for exactly one cycle per completed grant and low otherwise.
- Throughput: one sample per DWELL_CYC cycles under continuous requests. Latency from the granting edge to data_valid is DWELL_CYC cycles.
- Fairness: with all 8 requesting, grants go 0,1,...,7,0,... No source waits more than 7 grants.
- Single requester with continuous req: it is regranted every dwell, ptr wraps to itself.
- cnt width is 4 bits; DWELL_CYC=1 means cnt==0 on the first DWELL cycle.
- Same-edge req/arbitration: req is sampled only at the arbitration edge; changes mid-dwell are ignored until the next one.

Optional Feature:
MUX8_SCHED_LOCK_EN
- Defined: at a dwell end, if lock[sel] and req[sel] are both 1, the same source is regranted. ptr is still updated for data_idx, but the pick ignores other requesters. The lock is released when either bit drops at a dwell-end edge.
- Undefined: the lock port is ignored (left unconnected internally) and behaviour is pure round-robin.

Decomposition:
- Package mux8_sched_pkg:
  - N_SRC=8, SEL_W=3, CNT_W=4.
  - State enum {IDLE, DWELL}.
  - Helper function onehot8(idx).
- Sub-module rr_pick8: combinational; inputs req[7:0] and ptr[2:0]; outputs idx[2:0] and any.
- The top holds the FSM, the counter and the output registers.

Test Plan:
- Reset mid-dwell: DWELL_CYC=2, req=8'h01, assert reset 1 cycle after grant -> all outputs 0 immediately, no data_valid. After release with req still 8'h01 -> grant=8'h01 at the next edge.
- Single request: req=8'h20 held one cycle, S5 drives F=1 -> sel=3'b101 (W0=1,W1=0,W2=1) next edge, busy=1. 2 edges later: data_valid=1, data_out=1, data_idx=5, grant=0, busy=0.
- All request: req=8'hFF continuous, DWELL_CYC=2 -> data_idx sequence 0,1,2,...,7,0 at 2-cycle spacing, with grant changing at the same edge as each data_valid.
- Wrap and skip: after a grant to 6, req=8'h41 -> next grant 0, then 6, then 0 (alternating); ptr wrap past 7 verified.
- Req drop: req=8'h08 dropped one cycle after grant, DWELL_CYC=4 -> grant held 4 cycles, one data_valid with data_idx=3, then IDLE.
- Lock (MUX8_SCHED_LOCK_EN defined): req=8'h03, lock=8'h01 -> source 0 is regranted every dwell. Lock drops -> the next grant is 1. With the macro undefined, the same stimulus alternates 0,1.
